// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, 1-entry skid and redirect flush.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pcplus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pcplus4_q, id_pcplus4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pcplus4_q, skid_pcplus4_d;
  logic        fetch_ok;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    id_valid_d     = id_valid_q;
    id_instr_d     = id_instr_q;
    id_pcplus4_d   = id_pcplus4_q;
    skid_instr_d   = skid_instr_q;
    skid_pcplus4_d = skid_pcplus4_q;
    fetch_ok       = 1'b0;
    if (id_valid_q && id_ready) id_valid_d = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_target;
      id_valid_d = 1'b0;
      // A request still awaiting its response must be drained before a new one issues.
      case (state_q)
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_WAIT : S_DROP;
        default:        state_d = S_WAIT;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            fetch_ok = 1'b1;
            pc_d     = pc_plus4;
            if (!id_valid_q || id_ready) begin
              id_instr_d   = imem_rdata;
              id_pcplus4_d = pc_plus4;
              id_valid_d   = 1'b1;
            end else begin
              skid_instr_d   = imem_rdata;
              skid_pcplus4_d = pc_plus4;
              state_d        = S_STALL;
            end
          end
        end
        S_STALL: begin
          if (id_ready) begin
            id_instr_d   = skid_instr_q;
            id_pcplus4_d = skid_pcplus4_q;
            id_valid_d   = 1'b1;
            state_d      = S_WAIT;
          end
        end
        S_DROP: if (imem_rvalid) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      id_valid_q     <= 1'b0;
      id_instr_q     <= 32'd0;
      id_pcplus4_q   <= 32'd0;
      skid_instr_q   <= 32'd0;
      skid_pcplus4_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      id_valid_q     <= id_valid_d;
      id_instr_q     <= id_instr_d;
      id_pcplus4_q   <= id_pcplus4_d;
      skid_instr_q   <= skid_instr_d;
      skid_pcplus4_q <= skid_pcplus4_d;
    end
  end

  assign imem_req   = (state_q == S_WAIT);
  assign imem_addr  = pc_q;
  assign id_valid   = id_valid_q;
  assign id_instr   = id_instr_q;
  assign id_opcode  = id_instr_q[31:26];
  assign id_pcplus4 = id_pcplus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (fetch_ok) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (id_valid_q && !id_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  logic unused_fetch_ok;
  assign unused_fetch_ok = fetch_ok;
`endif

endmodule
